// File: rtl/rr_mux_arbiter.sv
// Purpose: round-robin arbiter driving the select of an N-input data mux from valid/ready requesters.
// Latency: grant registered one cycle after a request is seen idle; back-to-back grants give 1 transfer/cycle.
// Backpressure: out_ready_i low holds sel_o/grant_o/out_valid_o and keeps req_ready_o at zero.
//
// Ports:
//   clk_i        clock, all state on rising edge
//   reset_i      synchronous active-high reset
//   req_valid_i  per-source request (source k drives mux input k)
//   req_ready_o  per-source accept, one-hot or zero, combinational (asserted on the downstream handshake)
//   sel_o        registered binary mux select of the granted source
//   grant_o      registered one-hot grant, zero when no grant is held
//   out_valid_o  registered, mux output valid for downstream
//   out_ready_i  downstream accepts the mux output
module rr_mux_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int SEL_W   = $clog2(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [NUM_REQ-1:0] req_valid_i,
    output logic [NUM_REQ-1:0] req_ready_o,
    output logic [SEL_W-1:0]   sel_o,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               out_valid_o,
    input  logic               out_ready_i
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     ptr_q, ptr_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;

    logic                 xfer;
    logic [SEL_W-1:0]     sel_next_ptr;
    logic [SEL_W-1:0]     scan_start;
    logic [NUM_REQ-1:0]   scan_req;
    logic                 scan_found;
    logic [SEL_W-1:0]     scan_idx;
    logic [NUM_REQ-1:0]   scan_onehot;

    // A handshake is never reported while reset is asserted, so a grant
    // pending at reset is simply dropped.
    assign xfer = (state_q == BUSY) && out_ready_i && !reset_i;

    // Pointer increment wraps at NUM_REQ, not at 2^SEL_W, so non-power-of-two
    // requester counts never produce an out-of-range select.
    assign sel_next_ptr = (sel_q == SEL_W'(NUM_REQ - 1)) ? '0 : sel_q + 1'b1;

    // Circular priority scan without modulo arithmetic: the first pass takes
    // the lowest request at or above scan_start; if none, the second pass
    // takes the lowest request overall, which is the wrapped-around winner.
    always_comb begin
        scan_found = 1'b0;
        scan_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!scan_found && scan_req[i] && (SEL_W'(i) >= scan_start)) begin
                scan_found = 1'b1;
                scan_idx   = SEL_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!scan_found && scan_req[i]) begin
                scan_found = 1'b1;
                scan_idx   = SEL_W'(i);
            end
        end
    end

    assign scan_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << scan_idx;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sel_d       = sel_q;
        grant_d     = grant_q;
        scan_start  = ptr_q;
        scan_req    = req_valid_i;
        req_ready_o = '0;

        case (state_q)
            IDLE: begin
                if (|req_valid_i) begin
                    sel_d   = scan_idx;
                    grant_d = scan_onehot;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (xfer) begin
                    req_ready_o = grant_q;
                    ptr_d       = sel_next_ptr;
                    // Re-arbitrate from the advanced pointer with the source
                    // just served masked out, so a lone requester cannot
                    // monopolise consecutive cycles.
                    scan_start  = sel_next_ptr;
                    scan_req    = req_valid_i & ~grant_q;
                    if (scan_found) begin
                        sel_d   = scan_idx;
                        grant_d = scan_onehot;
                    end else begin
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
        end
    end

    assign sel_o       = sel_q;
    assign grant_o     = grant_q;
    assign out_valid_o = (state_q == BUSY);

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: one 4-requester and one 3-requester instance.
// Inputs change 1 time unit after the rising edge; outputs are checked a further unit later.
// Each scenario task does its own inline comparisons against hand-computed values.
module tb_rr_mux_arbiter;

    logic       clk = 1'b0;
    logic       rst;

    logic [3:0] rv4, rr4, gnt4;
    logic [1:0] sel4;
    logic       ov4, or4;

    logic [2:0] rv3, rr3, gnt3;
    logic [1:0] sel3;
    logic       ov3, or3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rr_mux_arbiter #(.NUM_REQ(4)) u4 (
        .clk_i       (clk),
        .reset_i     (rst),
        .req_valid_i (rv4),
        .req_ready_o (rr4),
        .sel_o       (sel4),
        .grant_o     (gnt4),
        .out_valid_o (ov4),
        .out_ready_i (or4)
    );

    rr_mux_arbiter #(.NUM_REQ(3)) u3 (
        .clk_i       (clk),
        .reset_i     (rst),
        .req_valid_i (rv3),
        .req_ready_o (rr3),
        .sel_o       (sel3),
        .grant_o     (gnt3),
        .out_valid_o (ov3),
        .out_ready_i (or3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rv4 = 4'b1111; or4 = 1'b1;
        rv3 = 3'b111;  or3 = 1'b1;
        tick();
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if (ov4 !== 1'b0)    begin errors++; $display("FAIL reset_ov4 got=%b exp=0", ov4); end
            checks++; if (sel4 !== 2'd0)   begin errors++; $display("FAIL reset_sel4 got=%0d exp=0", sel4); end
            checks++; if (gnt4 !== 4'b0)   begin errors++; $display("FAIL reset_gnt4 got=%b exp=0000", gnt4); end
            checks++; if (rr4 !== 4'b0)    begin errors++; $display("FAIL reset_rr4 got=%b exp=0000", rr4); end
            checks++; if (ov3 !== 1'b0)    begin errors++; $display("FAIL reset_ov3 got=%b exp=0", ov3); end
            checks++; if (gnt3 !== 3'b0)   begin errors++; $display("FAIL reset_gnt3 got=%b exp=000", gnt3); end
            checks++; if (rr3 !== 3'b0)    begin errors++; $display("FAIL reset_rr3 got=%b exp=000", rr3); end
            tick();
        end
        rst = 1'b0;
        rv4 = 4'b0000;
        rv3 = 3'b000;
        tick();
    endtask

    // All four requesting with downstream always ready: 0,1,2,3,0,1 back to back.
    task automatic test_round_robin();
        logic [3:0] exp_oh;
        logic [1:0] exp_sel;
        rv4 = 4'b1111; or4 = 1'b1;
        #1;
        checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL rr_idle_ov got=%b exp=0", ov4); end
        checks++; if (rr4 !== 4'b0) begin errors++; $display("FAIL rr_idle_ready got=%b exp=0000", rr4); end
        tick();
        for (int k = 0; k < 6; k++) begin
            exp_sel = 2'(k % 4);
            exp_oh  = 4'b0001 << exp_sel;
            #1;
            checks++; if (ov4 !== 1'b1)     begin errors++; $display("FAIL rr_ov[%0d] got=%b exp=1", k, ov4); end
            checks++; if (sel4 !== exp_sel) begin errors++; $display("FAIL rr_sel[%0d] got=%0d exp=%0d", k, sel4, exp_sel); end
            checks++; if (gnt4 !== exp_oh)  begin errors++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", k, gnt4, exp_oh); end
            checks++; if (rr4 !== exp_oh)   begin errors++; $display("FAIL rr_ready[%0d] got=%b exp=%b", k, rr4, exp_oh); end
            tick();
        end
    endtask

    // Grant sits on source 2 (left there by the round-robin run); stall 5 cycles.
    task automatic test_backpressure();
        or4 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (sel4 !== 2'd2)    begin errors++; $display("FAIL bp_sel[%0d] got=%0d exp=2", c, sel4); end
            checks++; if (gnt4 !== 4'b0100) begin errors++; $display("FAIL bp_gnt[%0d] got=%b exp=0100", c, gnt4); end
            checks++; if (ov4 !== 1'b1)     begin errors++; $display("FAIL bp_ov[%0d] got=%b exp=1", c, ov4); end
            checks++; if (rr4 !== 4'b0)     begin errors++; $display("FAIL bp_ready[%0d] got=%b exp=0000", c, rr4); end
            tick();
        end
        or4 = 1'b1;
        #1;
        checks++; if (rr4 !== 4'b0100) begin errors++; $display("FAIL bp_release got=%b exp=0100", rr4); end
        tick();
        or4 = 1'b0;
        #1;
        checks++; if (rr4 !== 4'b0)     begin errors++; $display("FAIL bp_one_cycle got=%b exp=0000", rr4); end
        checks++; if (sel4 !== 2'd3)    begin errors++; $display("FAIL bp_next_sel got=%0d exp=3", sel4); end
        checks++; if (gnt4 !== 4'b1000) begin errors++; $display("FAIL bp_next_gnt got=%b exp=1000", gnt4); end
        rv4 = 4'b0000; or4 = 1'b1;
        #1;
        checks++; if (rr4 !== 4'b1000) begin errors++; $display("FAIL bp_drain got=%b exp=1000", rr4); end
        tick();
        #1;
        checks++; if (ov4 !== 1'b0)  begin errors++; $display("FAIL bp_idle_ov got=%b exp=0", ov4); end
        checks++; if (gnt4 !== 4'b0) begin errors++; $display("FAIL bp_idle_gnt got=%b exp=0000", gnt4); end
    endtask

    // Lone source 1 alternates idle/busy; afterwards ptr=2 makes 3 beat 0.
    task automatic test_single_requester();
        rv4 = 4'b0010; or4 = 1'b1;
        for (int rep = 0; rep < 2; rep++) begin
            #1;
            checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL single_gap[%0d] got=%b exp=0", rep, ov4); end
            tick();
            #1;
            checks++; if (ov4 !== 1'b1)     begin errors++; $display("FAIL single_ov[%0d] got=%b exp=1", rep, ov4); end
            checks++; if (sel4 !== 2'd1)    begin errors++; $display("FAIL single_sel[%0d] got=%0d exp=1", rep, sel4); end
            checks++; if (rr4 !== 4'b0010)  begin errors++; $display("FAIL single_ready[%0d] got=%b exp=0010", rep, rr4); end
            if (rep == 1) rv4 = 4'b1001;
            tick();
        end
        #1;
        checks++; if (sel4 !== 2'd3)   begin errors++; $display("FAIL single_ptr_sel got=%0d exp=3", sel4); end
        checks++; if (rr4 !== 4'b1000) begin errors++; $display("FAIL single_ptr_ready got=%b exp=1000", rr4); end
        rv4 = 4'b0001;
        tick();
        #1;
        checks++; if (sel4 !== 2'd0)   begin errors++; $display("FAIL single_wrap_sel got=%0d exp=0", sel4); end
        checks++; if (rr4 !== 4'b0001) begin errors++; $display("FAIL single_wrap_ready got=%b exp=0001", rr4); end
        rv4 = 4'b0000;
        tick();
        #1;
        checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL single_end_ov got=%b exp=0", ov4); end
    endtask

    // NUM_REQ=3: park ptr at 1, then requests on 0 and 2 grant 2 then 0.
    task automatic test_wrap3();
        logic [1:0] exp_seq [4];
        exp_seq = '{2'd1, 2'd2, 2'd0, 2'd1};
        rv3 = 3'b001; or3 = 1'b1;
        tick();
        #1;
        checks++; if (sel3 !== 2'd0)  begin errors++; $display("FAIL wrap_prime_sel got=%0d exp=0", sel3); end
        checks++; if (rr3 !== 3'b001) begin errors++; $display("FAIL wrap_prime_ready got=%b exp=001", rr3); end
        rv3 = 3'b000;
        tick();
        #1;
        checks++; if (ov3 !== 1'b0) begin errors++; $display("FAIL wrap_idle got=%b exp=0", ov3); end
        rv3 = 3'b101;
        tick();
        #1;
        checks++; if (sel3 !== 2'd2)   begin errors++; $display("FAIL wrap_first_sel got=%0d exp=2", sel3); end
        checks++; if (gnt3 !== 3'b100) begin errors++; $display("FAIL wrap_first_gnt got=%b exp=100", gnt3); end
        checks++; if (rr3 !== 3'b100)  begin errors++; $display("FAIL wrap_first_ready got=%b exp=100", rr3); end
        rv3 = 3'b001;
        tick();
        #1;
        checks++; if (sel3 !== 2'd0)   begin errors++; $display("FAIL wrap_second_sel got=%0d exp=0", sel3); end
        checks++; if (gnt3 !== 3'b001) begin errors++; $display("FAIL wrap_second_gnt got=%b exp=001", gnt3); end
        checks++; if (rr3 !== 3'b001)  begin errors++; $display("FAIL wrap_second_ready got=%b exp=001", rr3); end
        rv3 = 3'b000;
        tick();
        // ptr is now 1; all three requesting rotates 1,2,0,1 and never shows 3.
        rv3 = 3'b111;
        tick();
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (sel3 !== exp_seq[k]) begin errors++; $display("FAIL wrap_all_sel[%0d] got=%0d exp=%0d", k, sel3, exp_seq[k]); end
            checks++; if (ov3 !== 1'b1)        begin errors++; $display("FAIL wrap_all_ov[%0d] got=%b exp=1", k, ov3); end
            tick();
        end
        rv3 = 3'b000;
        tick();
        tick();
    endtask

    // Reset while a grant is live and downstream is ready: no accept, outputs clear, ptr back to 0.
    task automatic test_reset_mid_busy();
        rv4 = 4'b1111; or4 = 1'b1;
        tick();
        #1;
        checks++; if (ov4 !== 1'b1)  begin errors++; $display("FAIL mid_pre_ov got=%b exp=1", ov4); end
        checks++; if (sel4 !== 2'd1) begin errors++; $display("FAIL mid_pre_sel got=%0d exp=1", sel4); end
        rst = 1'b1;
        #1;
        checks++; if (rr4 !== 4'b0) begin errors++; $display("FAIL mid_ready got=%b exp=0000", rr4); end
        tick();
        #1;
        checks++; if (ov4 !== 1'b0)  begin errors++; $display("FAIL mid_ov got=%b exp=0", ov4); end
        checks++; if (sel4 !== 2'd0) begin errors++; $display("FAIL mid_sel got=%0d exp=0", sel4); end
        checks++; if (gnt4 !== 4'b0) begin errors++; $display("FAIL mid_gnt got=%b exp=0000", gnt4); end
        checks++; if (rr4 !== 4'b0)  begin errors++; $display("FAIL mid_rr got=%b exp=0000", rr4); end
        rst = 1'b0;
        rv4 = 4'b1001;
        tick();
        #1;
        checks++; if (sel4 !== 2'd0)    begin errors++; $display("FAIL mid_ptr_sel got=%0d exp=0", sel4); end
        checks++; if (gnt4 !== 4'b0001) begin errors++; $display("FAIL mid_ptr_gnt got=%b exp=0001", gnt4); end
        rv4 = 4'b0000;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        rv4 = 4'b0; or4 = 1'b0;
        rv3 = 3'b0; or3 = 1'b0;
        test_reset();
        test_round_robin();
        test_backpressure();
        test_single_requester();
        test_wrap3();
        test_reset_mid_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
